// File: rtl/cpu_gen2_pkg.sv
// Shared opcode encodings and sequencer stage definitions for the gen2 accumulator core.
package cpu_gen2_pkg;

    localparam int unsigned OPCODE_WIDTH = 4;
    localparam int unsigned STAGE_WIDTH  = 3;

    localparam logic [OPCODE_WIDTH-1:0] OP_NOP = 4'h0;
    localparam logic [OPCODE_WIDTH-1:0] OP_LDA = 4'h1;
    localparam logic [OPCODE_WIDTH-1:0] OP_ADD = 4'h2;
    localparam logic [OPCODE_WIDTH-1:0] OP_SUB = 4'h3;
    localparam logic [OPCODE_WIDTH-1:0] OP_STA = 4'h4;
    localparam logic [OPCODE_WIDTH-1:0] OP_LDI = 4'h7;
    localparam logic [OPCODE_WIDTH-1:0] OP_JZ  = 4'h8;
    localparam logic [OPCODE_WIDTH-1:0] OP_JC  = 4'hB;
    localparam logic [OPCODE_WIDTH-1:0] OP_JMP = 4'hC;
    localparam logic [OPCODE_WIDTH-1:0] OP_OUT = 4'hE;
    localparam logic [OPCODE_WIDTH-1:0] OP_HLT = 4'hF;

    typedef enum logic [STAGE_WIDTH-1:0] {
        ST_HALT = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_T3   = 3'd3,
        ST_T4   = 3'd4,
        ST_T5   = 3'd5
    } stage_e;

endpackage

// File: rtl/cpu_gen2_addsub.sv
// Combinational adder/subtractor; carry is the no-borrow flag when subtracting.
module cpu_gen2_addsub #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero
);

    logic [WIDTH-1:0] b_eff_c;
    logic [WIDTH:0]   sum_c;

    // Subtraction as A + ~B + 1
    always_comb begin
        b_eff_c = sub ? ~b : b;
        sum_c   = {1'b0, a} + {1'b0, b_eff_c} + (WIDTH+1)'(sub);
    end

    assign result = sum_c[WIDTH-1:0];
    assign carry  = sum_c[WIDTH];
    assign zero   = (sum_c[WIDTH-1:0] == '0);

endmodule

// File: rtl/cpu_seq_gen2.sv
// Gen2 accumulator CPU: multi-stage sequencer, register file, flags and unified memory.
module cpu_seq_gen2
    import cpu_gen2_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 4,
    parameter int unsigned LED_COUNT     = 5
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  run,
    input  logic                                  prog_we,
    input  logic [ADDRESS_WIDTH-1:0]              prog_addr,
    input  logic [OPCODE_WIDTH+ADDRESS_WIDTH-1:0] prog_data,
    output logic [LED_COUNT-1:0]                  leds,
    output logic                                  out_valid,
    output logic                                  halted,
    output logic [ADDRESS_WIDTH-1:0]              dbg_pc,
    output logic [OPCODE_WIDTH+ADDRESS_WIDTH-1:0] dbg_a
);

    localparam int unsigned WIDTH = OPCODE_WIDTH + ADDRESS_WIDTH;
    localparam int unsigned DEPTH = 2 ** ADDRESS_WIDTH;

    stage_e                    state_q, state_d;
    logic [ADDRESS_WIDTH-1:0]  pc_q, pc_d;
    logic [ADDRESS_WIDTH-1:0]  mar_q, mar_d;
    logic [WIDTH-1:0]          ir_q, ir_d;
    logic [WIDTH-1:0]          a_q, a_d;
    logic [WIDTH-1:0]          b_q, b_d;
    logic                      c_q, c_d;
    logic                      z_q, z_d;
    logic [LED_COUNT-1:0]      leds_q, leds_d;
    logic                      out_valid_q, out_valid_d;
    logic                      halted_q, halted_d;

    logic [WIDTH-1:0]          mem [DEPTH];
    logic [WIDTH-1:0]          mem_rd_c;
    logic                      mem_we_c;
    logic [ADDRESS_WIDTH-1:0]  mem_waddr_c;
    logic [WIDTH-1:0]          mem_wdata_c;

    logic [OPCODE_WIDTH-1:0]   opcode_c;
    logic [ADDRESS_WIDTH-1:0]  operand_c;
    logic [WIDTH-1:0]          alu_result_c;
    logic                      alu_carry_c;
    logic                      alu_zero_c;

    assign opcode_c  = ir_q[WIDTH-1:ADDRESS_WIDTH];
    assign operand_c = ir_q[ADDRESS_WIDTH-1:0];
    assign mem_rd_c  = mem[mar_q];

    cpu_gen2_addsub #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .a      (a_q),
        .b      (b_q),
        .sub    (opcode_c == OP_SUB),
        .result (alu_result_c),
        .carry  (alu_carry_c),
        .zero   (alu_zero_c)
    );

    // Sequencer next-state and register update decode
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        mar_d       = mar_q;
        ir_d        = ir_q;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        z_d         = z_q;
        leds_d      = leds_q;
        out_valid_d = 1'b0;
        mem_we_c    = 1'b0;
        mem_waddr_c = mar_q;
        mem_wdata_c = a_q;

        case (state_q)
            ST_HALT: begin
                if (prog_we) begin
                    mem_we_c    = 1'b1;
                    mem_waddr_c = prog_addr;
                    mem_wdata_c = prog_data;
                end
                if (run) begin
                    state_d = ST_T1;
                end
            end
            ST_T1: begin
                mar_d   = pc_q;
                state_d = ST_T2;
            end
            ST_T2: begin
                ir_d    = mem_rd_c;
                pc_d    = pc_q + ADDRESS_WIDTH'(1);
                state_d = ST_T3;
            end
            ST_T3: begin
                state_d = ST_T1;
                case (opcode_c)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        mar_d   = operand_c;
                        state_d = ST_T4;
                    end
                    OP_LDI: a_d = {{OPCODE_WIDTH{1'b0}}, operand_c};
                    OP_JZ:  if (z_q) pc_d = operand_c;
                    OP_JC:  if (c_q) pc_d = operand_c;
                    OP_JMP: pc_d = operand_c;
                    OP_OUT: begin
                        leds_d      = a_q[LED_COUNT-1:0];
                        out_valid_d = 1'b1;
                    end
                    OP_HLT: state_d = ST_HALT;
                    OP_NOP: state_d = ST_T1;
                    default: state_d = ST_T1;
                endcase
            end
            ST_T4: begin
                state_d = ST_T1;
                case (opcode_c)
                    OP_LDA: a_d = mem_rd_c;
                    OP_ADD, OP_SUB: begin
                        b_d     = mem_rd_c;
                        state_d = ST_T5;
                    end
                    OP_STA: mem_we_c = 1'b1;
                    default: state_d = ST_T1;
                endcase
            end
            ST_T5: begin
                a_d     = alu_result_c;
                c_d     = alu_carry_c;
                z_d     = alu_zero_c;
                state_d = ST_T1;
            end
            default: state_d = ST_HALT;
        endcase

        halted_d = (state_d == ST_HALT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_HALT;
            pc_q        <= '0;
            mar_q       <= '0;
            ir_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= 1'b0;
            z_q         <= 1'b0;
            leds_q      <= '0;
            out_valid_q <= 1'b0;
            halted_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            mar_q       <= mar_d;
            ir_q        <= ir_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            z_q         <= z_d;
            leds_q      <= leds_d;
            out_valid_q <= out_valid_d;
            halted_q    <= halted_d;
        end
    end

    // Memory contents survive reset; writes are suppressed while reset is held
    always_ff @(posedge clk) begin
        if (mem_we_c && rst_n) begin
            mem[mem_waddr_c] <= mem_wdata_c;
        end
    end

    assign leds      = leds_q;
    assign out_valid = out_valid_q;
    assign halted    = halted_q;
    assign dbg_pc    = pc_q;
    assign dbg_a     = a_q;

endmodule

// File: tb/tb_cpu_seq_gen2.sv
// Self-checking bench for cpu_seq_gen2: directed programs plus random programs against an ISA-level model.
module tb_cpu_seq_gen2;

    logic       clk;
    logic       rst_n;
    logic       run;
    logic       prog_we;
    logic [3:0] prog_addr;
    logic [7:0] prog_data;
    logic [4:0] leds;
    logic       out_valid;
    logic       halted;
    logic [3:0] dbg_pc;
    logic [7:0] dbg_a;

    int checks;
    int failures;

    // Instruction-level reference state
    logic [7:0] mem_m [16];
    logic [3:0] pc_m;
    logic [7:0] a_m;
    logic       c_m;
    logic       z_m;
    logic [4:0] leds_m;

    cpu_seq_gen2 #(
        .ADDRESS_WIDTH (4),
        .LED_COUNT     (5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .leds      (leds),
        .out_valid (out_valid),
        .halted    (halted),
        .dbg_pc    (dbg_pc),
        .dbg_a     (dbg_a)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(output int cyc, output bit is_out, output bit is_hlt);
        logic [7:0] instr;
        logic [3:0] op;
        logic [3:0] opd;
        int r;
        instr  = mem_m[pc_m];
        op     = instr[7:4];
        opd    = instr[3:0];
        pc_m   = pc_m + 4'd1;
        cyc    = 3;
        is_out = 1'b0;
        is_hlt = 1'b0;
        case (op)
            4'h1: begin a_m = mem_m[opd]; cyc = 4; end
            4'h2: begin
                r   = int'(a_m) + int'(mem_m[opd]);
                c_m = (r > 255);
                a_m = 8'(r);
                z_m = (a_m == 8'd0);
                cyc = 5;
            end
            4'h3: begin
                r   = int'(a_m) - int'(mem_m[opd]);
                c_m = (r >= 0);
                a_m = 8'(r);
                z_m = (a_m == 8'd0);
                cyc = 5;
            end
            4'h4: begin mem_m[opd] = a_m; cyc = 4; end
            4'h7: a_m = {4'h0, opd};
            4'h8: if (z_m) pc_m = opd;
            4'hB: if (c_m) pc_m = opd;
            4'hC: pc_m = opd;
            4'hE: begin leds_m = a_m[4:0]; is_out = 1'b1; end
            4'hF: is_hlt = 1'b1;
            default: ;
        endcase
    endtask

    task automatic noise();
        prog_we   = 1'($urandom_range(0, 1));
        prog_addr = 4'($urandom);
        prog_data = 8'($urandom);
    endtask

    task automatic do_reset();
        prog_we = 1'b0;
        run     = 1'b0;
        rst_n   = 1'b0;
        #2;
        chk("rst_halted", {31'd0, halted}, 32'd1);
        chk("rst_leds", {27'd0, leds}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_pc", {28'd0, dbg_pc}, 32'd0);
        chk("rst_a", {24'd0, dbg_a}, 32'd0);
        @(posedge clk); #1;
        rst_n  = 1'b1;
        pc_m   = 4'd0;
        a_m    = 8'd0;
        c_m    = 1'b0;
        z_m    = 1'b0;
        leds_m = 5'd0;
    endtask

    task automatic load_word(input logic [3:0] addr, input logic [7:0] data);
        prog_we   = 1'b1;
        prog_addr = addr;
        prog_data = data;
        @(posedge clk); #1;
        prog_we   = 1'b0;
        mem_m[addr] = data;
    endtask

    // Run up to max_instr instructions, checking every cycle against the model
    task automatic run_prog(input int max_instr, output bit did_halt);
        int cyc;
        bit is_out;
        bit is_hlt;
        did_halt = 1'b0;
        chk("halted_pre", {31'd0, halted}, 32'd1);
        prog_we = 1'b0;
        run = 1'b1;
        @(posedge clk); #1;
        run = 1'b0;
        chk("halted_run", {31'd0, halted}, 32'd0);
        for (int n = 0; n < max_instr; n++) begin
            model_step(cyc, is_out, is_hlt);
            for (int k = 1; k <= cyc; k++) begin
                noise();
                @(posedge clk); #1;
                prog_we = 1'b0;
                chk("out_valid", {31'd0, out_valid}, {31'd0, (k == cyc) && is_out});
            end
            chk("pc", {28'd0, dbg_pc}, {28'd0, pc_m});
            chk("a", {24'd0, dbg_a}, {24'd0, a_m});
            chk("leds", {27'd0, leds}, {27'd0, leds_m});
            chk("halted", {31'd0, halted}, {31'd0, is_hlt});
            if (is_hlt) begin
                did_halt = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit h;
        logic [3:0] ops [12];
        ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h7, 4'h8, 4'hB, 4'hC, 4'hE, 4'hF, 4'h5};
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b1;
        run       = 1'b0;
        prog_we   = 1'b0;
        prog_addr = 4'd0;
        prog_data = 8'd0;
        #1;
        do_reset();
        for (int i = 0; i < 16; i++) load_word(4'(i), 8'h00);

        // Basic LDA/ADD/OUT/HLT
        load_word(4'd0, 8'h1E); load_word(4'd1, 8'h2F);
        load_word(4'd2, 8'hE0); load_word(4'd3, 8'hF0);
        load_word(4'd14, 8'h05); load_word(4'd15, 8'h07);
        run_prog(10, h);
        chk("t2_leds", {27'd0, leds}, 32'h0C);
        chk("t2_pc", {28'd0, dbg_pc}, 32'd4);

        // Carry and JC, taken then not taken
        do_reset();
        load_word(4'd0, 8'h7F); load_word(4'd1, 8'h25); load_word(4'd2, 8'hB6);
        load_word(4'd3, 8'hF0); load_word(4'd5, 8'hF5); load_word(4'd6, 8'hE0);
        load_word(4'd7, 8'hF0);
        run_prog(10, h);
        chk("t3_a_carry", {24'd0, dbg_a}, 32'h04);
        chk("t3_pc_taken", {28'd0, dbg_pc}, 32'd8);
        do_reset();
        load_word(4'd5, 8'h01);
        run_prog(10, h);
        chk("t3_a_nocarry", {24'd0, dbg_a}, 32'h10);
        chk("t3_pc_not_taken", {28'd0, dbg_pc}, 32'd4);

        // SUB and JZ, equal then borrow
        do_reset();
        load_word(4'd0, 8'h77); load_word(4'd1, 8'h35); load_word(4'd2, 8'h86);
        load_word(4'd3, 8'hF0); load_word(4'd5, 8'h07); load_word(4'd6, 8'hF0);
        run_prog(10, h);
        chk("t4_a_zero", {24'd0, dbg_a}, 32'h00);
        chk("t4_pc_jz_taken", {28'd0, dbg_pc}, 32'd7);
        do_reset();
        load_word(4'd0, 8'h73); load_word(4'd5, 8'h05);
        run_prog(10, h);
        chk("t4_a_borrow", {24'd0, dbg_a}, 32'hFE);
        chk("t4_pc_jz_not", {28'd0, dbg_pc}, 32'd4);

        // STA/LDA, then resume into a JMP to the top address and wrap
        do_reset();
        load_word(4'd0, 8'h79); load_word(4'd1, 8'h4D); load_word(4'd2, 8'h70);
        load_word(4'd3, 8'h1D); load_word(4'd4, 8'hF0);
        run_prog(10, h);
        chk("t5_a_sta_lda", {24'd0, dbg_a}, 32'h09);
        load_word(4'd0, 8'hF0); load_word(4'd5, 8'hCF); load_word(4'd15, 8'h00);
        run_prog(10, h);
        chk("t5_pc_wrap", {28'd0, dbg_pc}, 32'd1);

        // Reset during ADD T4
        do_reset();
        load_word(4'd0, 8'h2F); load_word(4'd15, 8'h07);
        run = 1'b1;
        @(posedge clk); #1;
        run = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_halted", {31'd0, halted}, 32'd1);
        chk("t6_pc", {28'd0, dbg_pc}, 32'd0);
        chk("t6_a", {24'd0, dbg_a}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        pc_m = 4'd0; a_m = 8'd0; c_m = 1'b0; z_m = 1'b0; leds_m = 5'd0;
        load_word(4'd0, 8'h1F); load_word(4'd1, 8'hE0); load_word(4'd2, 8'hF0);
        run_prog(10, h);
        chk("t6_readback", {27'd0, leds}, 32'h07);

        // Random programs, with resume after a halt
        for (int p = 0; p < 25; p++) begin
            do_reset();
            for (int i = 0; i < 16; i++) begin
                if ($urandom_range(0, 3) == 0)
                    load_word(4'(i), 8'($urandom));
                else
                    load_word(4'(i), {ops[$urandom_range(0, 11)], 4'($urandom)});
            end
            run_prog(40, h);
            if (h) run_prog(20, h);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_seq_gen2.md
Name: cpu_seq_gen2

Overview:
Second-generation parametrised accumulator CPU core. Holds program/data memory, PC, IR, registers A/B, carry/zero flags and a multi-stage control sequencer. Adds over the first generation: SUB, STA, JZ, NOP, a zero flag, a halt/resume handshake, a program-load port and an output strobe. Top-level core, driven by the board clock; drives the LEDs.

Parameters:
ADDRESS_WIDTH, 4, operand/address bits; memory depth = 2**ADDRESS_WIDTH.
LED_COUNT, 5, output register width; must be <= WIDTH.
(derived) WIDTH = 4 + ADDRESS_WIDTH, data and instruction width; opcode is bits [WIDTH-1:ADDRESS_WIDTH].

Ports:
clk  in  1  system clock, rising-edge.
rst_n  in  1  asynchronous active-low reset.
run  in  1  start/resume request, sampled only in HALT.
prog_we  in  1  memory load write enable, honoured only in HALT.
prog_addr  in  ADDRESS_WIDTH  load address.
prog_data  in  WIDTH  load data.
leds  out  LED_COUNT  output register.
out_valid  out  1  one-cycle strobe when leds is updated by OUT.
halted  out  1  high while in HALT.
dbg_pc  out  ADDRESS_WIDTH  current PC.
dbg_a  out  WIDTH  register A.

Behaviour:
- Reset (rst_n low, async): state=HALT, PC=0, IR=0, MAR=0, A=0, B=0, C=0, Z=0, leds=0, out_valid=0, halted=1. Memory is not cleared. Reset mid-instruction aborts it; a pending STA write is dropped.
- States: HALT, T1, T2, T3, T4, T5. Each stage lasts one clock.
- HALT: prog_we=1 writes mem[prog_addr]<=prog_data. run=1 goes to T1. If both are set, the write happens and the run is taken. prog_we is ignored in all other states.
- T1: MAR<=PC.
- T2: IR<=mem[MAR], PC<=PC+1 (wraps from 2**AW-1 to 0).
- T3 (execute, by opcode):
  - NOP 0000 -> T1.
  - LDA 0001, ADD 0010, SUB 0011, STA 0100: MAR<=operand -> T4.
  - LDI 0111: A<=zero-extended operand -> T1.
  - JZ 1000: if Z, PC<=operand -> T1.
  - JC 1011: if C, PC<=operand -> T1.
  - JMP 1100: PC<=operand -> T1.
  - OUT 1110: leds<=A[LED_COUNT-1:0], out_valid=1 for the next cycle only -> T1.
  - HLT 1111: -> HALT. PC already points past the HLT.
  - Undefined opcodes behave as NOP.
- T4:
  - LDA: A<=mem[MAR] -> T1.
  - ADD/SUB: B<=mem[MAR] -> T5.
  - STA: mem[MAR]<=A -> T1.
- T5: ADD: {C,A}<=A+B. SUB: {C,A}<=A+~B+1 (C=1 means no borrow). Z<=(new A==0). -> T1.
- Flags change only in T5. LDA and LDI do not touch flags.
- Memory read is combinational from MAR. Memory write is on the rising edge.
- Cycles per instruction: NOP/LDI/JMP/JC/JZ/OUT/HLT 3, LDA/STA 4, ADD/SUB 5.
- out_valid is never high for two consecutive cycles. halted is registered (state==HALT).

Decomposition:
- Package cpu_gen2_pkg: 4-bit opcode constants, stage enum/encodings (STAGE_WIDTH=3), OPCODE_WIDTH=4.
- One sub-module, cpu_gen2_addsub (parametrised WIDTH): combinational A, B, sub -> result, carry, zero.
- Sequencer, registers and memory stay in the top module.

Test Plan:
1. Reset and load: assert rst_n=0 -> halted=1, leds=0, out_valid=0, dbg_pc=0, dbg_a=0. Load memory while halted, then pulse run -> halted falls after 1 edge.
2. Basic program (AW=4): mem 0=0x1E (LDA 14), 1=0x2F (ADD 15), 2=0xE0 (OUT), 3=0xF0 (HLT), 14=0x05, 15=0x07; run -> out_valid rises after the 12th edge following run sample, for 1 cycle; leds=0x0C; then halted=1, dbg_pc=4.
3. Carry and JC: LDI 0x0F; ADD mem=0xF5 -> dbg_a=0x04, C=1; JC 6 taken -> dbg_pc=6. Repeat with mem=0x01 -> C=0, JC not taken.
4. SUB and JZ: A=0x07, SUB mem=0x07 -> A=0x00, Z=1, C=1; JZ taken. A=0x03, SUB 0x05 -> A=0xFE, C=0, Z=0; JZ not taken.
5. STA and PC wrap: LDI 9; STA 13; LDA 13 -> A=9. JMP 15 with NOP at 15 -> next fetch from address 0 (dbg_pc 15->0).
6. Reset mid-instruction: deassert rst_n during ADD T4 -> immediate reset values, halted=1. prog_we pulsed while running -> memory unchanged, readback via LDA/OUT.
